// File: rtl/fcmp_vec_pkg.sv
// fcmp_vec_pkg: shared op codes and control-field widths for the FP compare unit
//   fcmp_op_e : low three bits of the FPU function code
//   FN_*      : full 6-bit FPU dispatch codes, {3'b001, op}
package fcmp_vec_pkg;
    typedef enum logic [2:0] {
        OP_FEQ  = 3'd0,
        OP_FNE  = 3'd1,
        OP_FLE  = 3'd2,
        OP_FLT  = 3'd3,
        OP_FMAX = 3'd4,
        OP_FMIN = 3'd5
    } fcmp_op_e;
    localparam logic [5:0] FN_FEQ  = {3'b001, OP_FEQ};
    localparam logic [5:0] FN_FNE  = {3'b001, OP_FNE};
    localparam logic [5:0] FN_FLE  = {3'b001, OP_FLE};
    localparam logic [5:0] FN_FLT  = {3'b001, OP_FLT};
    localparam logic [5:0] FN_FMAX = {3'b001, OP_FMAX};
    localparam logic [5:0] FN_FMIN = {3'b001, OP_FMIN};
    localparam int REGIDX_WIDTH = 5;
    localparam int REGEXT_WIDTH = 3;
    localparam int DEPTH_WARP   = 3;
    // Only NV can ever be raised by a compare; DZ/OF/UF/NX stay clear.
    function automatic logic [4:0] nv_flags(input logic nv);
        return {nv, 4'b0000};
    endfunction
endpackage

// File: rtl/fcmp_vec_if.sv
// fcmp_vec_if: request/response bundle between FPU dispatch and the compare unit
//   request : in_valid, in_ready, op, signaling, a, b, ctrl_* (dispatch -> unit)
//   response: out_valid, out_ready, result, fflags, out_* ctrl (unit -> writeback)
//   master  : dispatch/writeback side, slave: the compare unit
interface fcmp_vec_if
    import fcmp_vec_pkg::*;
#(
    parameter int W        = 32,
    parameter int NUM_LANE = 4
);
    logic                                 in_valid;
    logic                                 in_ready;
    logic [2:0]                           op;
    logic                                 signaling;
    logic [NUM_LANE*W-1:0]                a;
    logic [NUM_LANE*W-1:0]                b;
    logic [REGIDX_WIDTH+REGEXT_WIDTH-1:0] ctrl_regindex;
    logic [DEPTH_WARP-1:0]                ctrl_warpid;
    logic [NUM_LANE-1:0]                  ctrl_vecmask;
    logic                                 ctrl_wvd;
    logic                                 ctrl_wxd;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [NUM_LANE*W-1:0]                result;
    logic [NUM_LANE*5-1:0]                fflags;
    logic [REGIDX_WIDTH+REGEXT_WIDTH-1:0] out_regindex;
    logic [DEPTH_WARP-1:0]                out_warpid;
    logic [NUM_LANE-1:0]                  out_vecmask;
    logic                                 out_wvd;
    logic                                 out_wxd;
    modport master (
        output in_valid, op, signaling, a, b, ctrl_regindex, ctrl_warpid, ctrl_vecmask,
               ctrl_wvd, ctrl_wxd, out_ready,
        input  in_ready, out_valid, result, fflags, out_regindex, out_warpid, out_vecmask,
               out_wvd, out_wxd
    );
    modport slave (
        input  in_valid, op, signaling, a, b, ctrl_regindex, ctrl_warpid, ctrl_vecmask,
               ctrl_wvd, ctrl_wxd, out_ready,
        output in_ready, out_valid, result, fflags, out_regindex, out_warpid, out_vecmask,
               out_wvd, out_wxd
    );
endinterface

// File: rtl/fcmp_vec_lane.sv
// fcmp_lane: combinational single-lane IEEE-754 compare / minNum / maxNum
//   a, b      : operands, W = EXPWIDTH+PRECISION bits
//   op        : fcmp_op_e code, signaling: FLT/FLE raise NV on any NaN
//   result    : compare bit in bit 0, or the selected min/max value
//   fflags    : {NV,DZ,OF,UF,NX}
module fcmp_lane
    import fcmp_vec_pkg::*;
#(
    parameter int EXPWIDTH  = 8,
    parameter int PRECISION = 24
) (
    input  logic [EXPWIDTH+PRECISION-1:0] a,
    input  logic [EXPWIDTH+PRECISION-1:0] b,
    input  logic [2:0]                    op,
    input  logic                          signaling,
    output logic [EXPWIDTH+PRECISION-1:0] result,
    output logic [4:0]                    fflags
);
    localparam int W = EXPWIDTH + PRECISION;
    localparam logic [W-1:0] CNAN = {1'b0, {EXPWIDTH{1'b1}}, 1'b1, {(PRECISION-2){1'b0}}};
    logic a_nan, b_nan, a_snan, b_snan, unord, any_snan, both_zero;
    logic eq, lt_raw, lt, cmp, is_cmp, is_mm, nv;
    logic [W-1:0] mm;
    assign a_nan     = (&a[W-2 -: EXPWIDTH]) & (|a[PRECISION-2:0]);
    assign b_nan     = (&b[W-2 -: EXPWIDTH]) & (|b[PRECISION-2:0]);
    assign a_snan    = a_nan & !a[PRECISION-2];
    assign b_snan    = b_nan & !b[PRECISION-2];
    assign unord     = a_nan | b_nan;
    assign any_snan  = a_snan | b_snan;
    assign both_zero = (a[W-2:0] == '0) & (b[W-2:0] == '0);
    assign eq        = (a == b) | both_zero;
    // Sign-magnitude order in which -0 sorts below +0; min/max use it as is,
    // compares mask the zero pair out so that +0 == -0.
    assign lt_raw = (a[W-1] != b[W-1]) ? a[W-1] :
                    a[W-1] ? (a[W-2:0] > b[W-2:0]) : (a[W-2:0] < b[W-2:0]);
    assign lt     = lt_raw & !both_zero;
    assign is_cmp = (op == OP_FEQ) | (op == OP_FNE) | (op == OP_FLE) | (op == OP_FLT);
    assign is_mm  = (op == OP_FMIN) | (op == OP_FMAX);
    assign cmp = (op == OP_FEQ) ? !unord & eq :
                 (op == OP_FNE) ? unord | !eq :
                 (op == OP_FLT) ? !unord & lt :
                 !unord & (lt | eq);
    assign mm = (a_nan & b_nan) ? CNAN :
                a_nan ? b :
                b_nan ? a :
                ((op == OP_FMIN) == lt_raw) ? a : b;
    assign nv = is_mm ? any_snan :
                !is_cmp ? 1'b0 :
                ((op == OP_FLT) | (op == OP_FLE)) & signaling ? unord : any_snan;
    assign result = is_cmp ? {{(W-1){1'b0}}, cmp} : is_mm ? mm : '0;
    assign fflags = nv_flags(nv);
endmodule

// File: rtl/fcmp_vec.sv
// fcmp_vec: NUM_LANE-wide FP compare/min-max unit with a LATENCY-deep elastic pipeline
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fcmp_vec_if.slave (request in, result/fflags/ctrl out, valid/ready both sides)
module fcmp_vec
    import fcmp_vec_pkg::*;
#(
    parameter int EXPWIDTH  = 8,
    parameter int PRECISION = 24,
    parameter int NUM_LANE  = 4,
    parameter int LATENCY   = 2
) (
    input logic       clk,
    input logic       rst,
    fcmp_vec_if.slave bus
);
    localparam int W  = EXPWIDTH + PRECISION;
    localparam int CW = REGIDX_WIDTH + REGEXT_WIDTH + DEPTH_WARP + NUM_LANE + 2;
    localparam int SW = NUM_LANE * (W + 5) + CW;
    logic [NUM_LANE*W-1:0] res;
    logic [NUM_LANE*5-1:0] flg;
    for (genvar i = 0; i < NUM_LANE; i++) begin : g_lane
        logic [W-1:0] r;
        logic [4:0]   f;
        fcmp_lane #(.EXPWIDTH(EXPWIDTH), .PRECISION(PRECISION)) u_lane (
            .a(bus.a[i*W +: W]),
            .b(bus.b[i*W +: W]),
            .op(bus.op),
            .signaling(bus.signaling),
            .result(r),
            .fflags(f)
        );
        assign res[i*W +: W] = bus.ctrl_vecmask[i] ? r : '0;
        assign flg[i*5 +: 5] = bus.ctrl_vecmask[i] ? f : '0;
    end
    // Each stage accepts when empty or when the stage after it drains this cycle.
    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        logic          v, r, nr, vin;
        logic [SW-1:0] q, din;
        if (k == 0) begin : g_head
            assign vin = bus.in_valid;
            assign din = {res, flg, bus.ctrl_regindex, bus.ctrl_warpid, bus.ctrl_vecmask,
                          bus.ctrl_wvd, bus.ctrl_wxd};
        end else begin : g_tail
            assign vin = g_stage[k-1].v;
            assign din = g_stage[k-1].q;
        end
        if (k == LATENCY - 1) begin : g_last
            assign nr = bus.out_ready;
        end else begin : g_mid
            assign nr = g_stage[k+1].r;
        end
        assign r = !v | nr;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v <= 1'b0;
                q <= '0;
            end else if (r) begin
                v <= vin;
                if (vin) q <= din;
            end
        end
    end
    assign bus.in_ready  = g_stage[0].r;
    assign bus.out_valid = g_stage[LATENCY-1].v;
    assign {bus.result, bus.fflags, bus.out_regindex, bus.out_warpid, bus.out_vecmask,
            bus.out_wvd, bus.out_wxd} = g_stage[LATENCY-1].q;
endmodule

// File: tb/tb_fcmp_vec.sv
// tb_fcmp_vec: directed bench for fcmp_vec with an ordering-key reference model and scoreboard
module tb_fcmp_vec;
    import fcmp_vec_pkg::*;
    localparam int W   = 32;
    localparam int NL  = 4;
    localparam int LAT = 2;
    localparam int RW  = REGIDX_WIDTH + REGEXT_WIDTH;
    localparam int OV  = NL * (W + 5) + RW + DEPTH_WARP + NL + 2;

    typedef struct {
        logic [NL*W-1:0]       res;
        logic [NL*5-1:0]       flg;
        logic [RW-1:0]         ri;
        logic [DEPTH_WARP-1:0] wid;
        logic [NL-1:0]         msk;
        logic                  wvd;
        logic                  wxd;
        int                    acc;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fcmp_vec_if #(.W(W), .NUM_LANE(NL)) bus ();
    fcmp_vec #(.EXPWIDTH(8), .PRECISION(24), .NUM_LANE(NL), .LATENCY(LAT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int out_cnt = 0;
    int stall_cnt = 0;
    int last_lat = 0;
    logic [NL*W-1:0] last_res;
    logic [NL*5-1:0] last_flg;
    logic [OV-1:0] snap;
    logic held = 1'b0;
    item_t q[$];
    item_t e;

    function automatic void check(string nm, logic [255:0] got, logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endfunction

    // Reference: map each non-NaN float onto a signed integer key whose order is
    // numeric order (both zeros map to 0), then apply the IEEE rules directly.
    function automatic logic [36:0] lane_model(logic [2:0] op, logic sig, logic [31:0] a, logic [31:0] b);
        logic an, bn, sn, un;
        longint ka, kb;
        logic [31:0] r;
        an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        sn = (an && !a[22]) || (bn && !b[22]);
        un = an || bn;
        ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
        kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
        case (op)
            OP_FEQ: return {31'd0, !un && ka == kb, sn, 4'd0};
            OP_FNE: return {31'd0, un || ka != kb, sn, 4'd0};
            OP_FLE: return {31'd0, !un && ka <= kb, sig ? un : sn, 4'd0};
            OP_FLT: return {31'd0, !un && ka < kb, sig ? un : sn, 4'd0};
            OP_FMIN, OP_FMAX: begin
                if (an && bn) r = 32'h7FC00000;
                else if (an) r = b;
                else if (bn) r = a;
                else if (ka == kb) r = ((op == OP_FMIN) == a[31]) ? a : b;
                else r = ((ka < kb) == (op == OP_FMIN)) ? a : b;
                return {r, sn, 4'd0};
            end
            default: return 37'd0;
        endcase
    endfunction

    function automatic item_t expect_txn();
        item_t x;
        logic [36:0] m;
        for (int i = 0; i < NL; i++) begin
            m = lane_model(bus.op, bus.signaling, bus.a[i*W +: W], bus.b[i*W +: W]);
            x.res[i*W +: W] = bus.ctrl_vecmask[i] ? m[36:5] : 32'd0;
            x.flg[i*5 +: 5] = bus.ctrl_vecmask[i] ? m[4:0] : 5'd0;
        end
        x.ri = bus.ctrl_regindex;
        x.wid = bus.ctrl_warpid;
        x.msk = bus.ctrl_vecmask;
        x.wvd = bus.ctrl_wvd;
        x.wxd = bus.ctrl_wxd;
        x.acc = 0;
        return x;
    endfunction

    function automatic logic [OV-1:0] out_vec();
        return {bus.result, bus.fflags, bus.out_regindex, bus.out_warpid, bus.out_vecmask,
                bus.out_wvd, bus.out_wxd};
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            held = 1'b0;
        end else begin
            if (held) check("hold_stable", {bus.out_valid, out_vec()}, {1'b1, snap});
            if (bus.in_valid && !bus.in_ready) stall_cnt++;
            if (bus.in_valid && bus.in_ready) begin
                e = expect_txn();
                e.acc = cyc;
                q.push_back(e);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_output got=%0h expected=none", bus.result);
                end else begin
                    e = q.pop_front();
                    check("scoreboard", out_vec(), {e.res, e.flg, e.ri, e.wid, e.msk, e.wvd, e.wxd});
                    last_lat = cyc - e.acc;
                end
                last_res = bus.result;
                last_flg = bus.fflags;
                out_cnt++;
            end
            held = bus.out_valid && !bus.out_ready;
            snap = out_vec();
        end
    end

    task automatic send(input logic [2:0] op, input logic sig, input logic [NL*W-1:0] a,
                        input logic [NL*W-1:0] b, input logic [NL-1:0] msk);
        int n = 0;
        bus.op = op;
        bus.signaling = sig;
        bus.a = a;
        bus.b = b;
        bus.ctrl_vecmask = msk;
        bus.ctrl_regindex = RW'($urandom);
        bus.ctrl_warpid = DEPTH_WARP'($urandom);
        bus.ctrl_wvd = 1'($urandom);
        bus.ctrl_wxd = 1'($urandom);
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run1(input string nm, input logic [2:0] op, input logic sig,
                        input logic [NL*W-1:0] a, input logic [NL*W-1:0] b, input logic [NL-1:0] msk,
                        input logic [31:0] exp_res, input logic [4:0] exp_flg);
        int c0 = out_cnt;
        int n = 0;
        send(op, sig, a, b, msk);
        while (out_cnt == c0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_emitted"}, out_cnt - c0, 1);
        check({nm, "_res"}, last_res[31:0], exp_res);
        check({nm, "_flg"}, last_flg[4:0], exp_flg);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] pool [12] = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'h00000000,
                               32'h80000000, 32'h7FC00000, 32'h7FA00000, 32'h00000001,
                               32'h807FFFFF, 32'h7F800000, 32'hFF800000, 32'hFFC00001};

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, s0, n;
        logic [NL*W-1:0] ra, rb;
        bus.in_valid = 1'b0;
        bus.op = 3'd0;
        bus.signaling = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.ctrl_regindex = '0;
        bus.ctrl_warpid = '0;
        bus.ctrl_vecmask = '0;
        bus.ctrl_wvd = 1'b0;
        bus.ctrl_wxd = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_outputs", out_vec(), 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("model_flt", lane_model(OP_FLT, 1'b0, 32'h3F800000, 32'h40000000), {32'd1, 5'd0});
        check("model_fmin_snan", lane_model(OP_FMIN, 1'b0, 32'h7FA00000, 32'h3F800000), {32'h3F800000, 5'b10000});
        check("model_fmin_zero", lane_model(OP_FMIN, 1'b0, 32'h00000000, 32'h80000000), {32'h80000000, 5'd0});

        run1("flt", OP_FLT, 1'b0, {32'h00000001, 32'hFF800000, 32'h80000001, 32'h3F800000},
             {32'h00000002, 32'h7F800000, 32'h00000000, 32'h40000000}, 4'hF, 32'd1, 5'd0);
        check("flt_latency", last_lat, LAT);
        run1("fmin_snan", OP_FMIN, 1'b0, {32'h00000000, 32'hBF800000, 32'h7FC00000, 32'h7FA00000},
             {32'h80000000, 32'h3F800000, 32'hC0000000, 32'h3F800000}, 4'hF, 32'h3F800000, 5'b10000);
        run1("fmax_qnan2", OP_FMAX, 1'b0, {32'h00800000, 32'h007FFFFF, 32'hFF800000, 32'h7FC00000},
             {32'h007FFFFF, 32'h00800000, 32'hFF7FFFFF, 32'hFFC00001}, 4'hF, 32'h7FC00000, 5'd0);
        run1("fle_quiet", OP_FLE, 1'b0, {32'h3F800000, 32'h80000000, 32'h7FA00000, 32'h7FC00000},
             {32'h3F800000, 32'h00000000, 32'h3F800000, 32'h00000000}, 4'hF, 32'd0, 5'd0);
        run1("fle_signal", OP_FLE, 1'b1, {32'h3F800000, 32'h80000000, 32'h7FA00000, 32'h7FC00000},
             {32'h3F800000, 32'h00000000, 32'h3F800000, 32'h00000000}, 4'hF, 32'd0, 5'b10000);
        run1("fne_nan", OP_FNE, 1'b0, {32'h80000000, 32'h7FA00000, 32'h3F800000, 32'h7FC00000},
             {32'h00000000, 32'h3F800000, 32'h3F800000, 32'h3F800000}, 4'hF, 32'd1, 5'd0);
        run1("fmin_zero", OP_FMIN, 1'b0, {32'h80000000, 32'h00000001, 32'h00000000, 32'h00000000},
             {32'h00000000, 32'h80000001, 32'h80000000, 32'h80000000}, 4'hF, 32'h80000000, 5'd0);
        run1("fmax_zero", OP_FMAX, 1'b0, {32'h80000000, 32'h00000001, 32'h00000000, 32'h00000000},
             {32'h00000000, 32'h80000001, 32'h80000000, 32'h80000000}, 4'hF, 32'h00000000, 5'd0);
        run1("feq_zero", OP_FEQ, 1'b0, {32'h7F800001, 32'h7FC00000, 32'h00000001, 32'h00000000},
             {32'h3F800000, 32'h7FC00000, 32'h00000001, 32'h80000000}, 4'hF, 32'd1, 5'd0);
        run1("undef_op6", 3'd6, 1'b0, {4{32'h7FA00000}}, {4{32'h3F800000}}, 4'hF, 32'd0, 5'd0);
        run1("undef_op7", 3'd7, 1'b1, {4{32'h3F800000}}, {4{32'h7FC00000}}, 4'hF, 32'd0, 5'd0);
        run1("mask", OP_FMAX, 1'b0, {4{32'h3F800000}}, {4{32'h40000000}}, 4'b0101, 32'h40000000, 5'd0);
        check("mask_lane1_res", last_res[63:32], 0);
        check("mask_lane3_res", last_res[127:96], 0);
        run1("mask_nv", OP_FMIN, 1'b0, {4{32'h7FA00000}}, {4{32'h3F800000}}, 4'b0101, 32'h3F800000, 5'b10000);
        check("mask_lane1_flg", last_flg[9:5], 0);
        check("mask_lane3_flg", last_flg[19:15], 0);

        c0 = out_cnt;
        s0 = stall_cnt;
        fork
            for (int j = 0; j < 6; j++) begin
                for (int l = 0; l < NL; l++) begin
                    ra[l*W +: W] = pool[$urandom_range(0, 11)];
                    rb[l*W +: W] = pool[$urandom_range(0, 11)];
                end
                send(3'(j), 1'(j), ra, rb, 4'($urandom_range(1, 15)));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        n = 0;
        while (out_cnt - c0 < 6 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_count", out_cnt - c0, 6);
        check("bp_in_ready_dropped", stall_cnt > s0, 1);
        @(posedge clk);
        #1;

        c0 = out_cnt;
        send(OP_FEQ, 1'b0, {4{32'h3F800000}}, {4{32'h3F800000}}, 4'hF);
        send(OP_FMAX, 1'b0, {4{32'h3F800000}}, {4{32'h40000000}}, 4'hF);
        check("flight_valid", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_flight_valid", bus.out_valid, 0);
        check("rst_flight_outputs", out_vec(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_emitted", out_cnt - c0, 0);
        check("drain_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
